// File: rtl/lc3_pkg.sv
// Shared types and helpers for the LC-3 fetch stage.
package lc3_pkg;

  localparam int unsigned LC3_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } fetch_state_t;

  typedef enum logic [1:0] {
    A2_ZERO,
    A2_OFF6,
    A2_OFF9,
    A2_OFF11
  } addr2_sel_t;

  // Sign-extended IR offset field selected by the ADDR2 mux.
  function automatic logic [LC3_WORD_W-1:0] sext_field(input logic [LC3_WORD_W-1:0] ir,
                                                       input addr2_sel_t sel);
    logic [LC3_WORD_W-1:0] res;
    res = '0;
    unique case (sel)
      A2_ZERO:  res = '0;
      A2_OFF6:  res = {{10{ir[5]}}, ir[5:0]};
      A2_OFF9:  res = {{7{ir[8]}}, ir[8:0]};
      A2_OFF11: res = {{5{ir[10]}}, ir[10:0]};
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lc3_addr_gen.sv
// Redirect target adder: ADDR1 (PC or base register) plus sign-extended IR offset.
module lc3_addr_gen
  import lc3_pkg::*;
(
  input  logic [LC3_WORD_W-1:0] pc_i,
  input  logic [LC3_WORD_W-1:0] base_reg_i,
  input  logic [LC3_WORD_W-1:0] ir_i,
  input  logic                  addr1_sel_i,
  input  logic [1:0]            addr2_sel_i,
  output logic [LC3_WORD_W-1:0] target_o
);

  logic [LC3_WORD_W-1:0] addr1;
  logic [LC3_WORD_W-1:0] addr2;

  always_comb begin
    addr1    = addr1_sel_i ? base_reg_i : pc_i;
    addr2    = sext_field(ir_i, addr2_sel_t'(addr2_sel_i));
    target_o = addr1 + addr2;
  end

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch stage: owns PC, MAR and IR, fetches over a req/ready
// handshake and computes the next PC on decoder acceptance.
module lc3_fetch_unit
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Run,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic              addr1_sel,
  input  logic [1:0]        addr2_sel,
  input  logic [DATA_W-1:0] base_reg,
  output logic [DATA_W-1:0] pc,
  output logic              busy
);

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] next_pc;

  lc3_addr_gen u_addr_gen (
    .pc_i       (pc_q),
    .base_reg_i (base_reg),
    .ir_i       (ir_q),
    .addr1_sel_i(addr1_sel),
    .addr2_sel_i(addr2_sel),
    .target_o   (target)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      mar_q   <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    next_pc = redirect ? target : pc_q;
    case (state_q)
      IDLE: begin
        if (Run) begin
          state_d = REQ;
          mar_d   = pc_q;
        end
      end
      REQ: begin
        // Run is not sampled here: an issued request always completes.
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ir_ready) begin
          pc_d    = next_pc;
          mar_d   = next_pc;
          state_d = Run ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req  = (state_q == REQ);
  assign mem_addr = mar_q;
  assign ir       = ir_q;
  assign ir_valid = (state_q == HOLD);
  assign pc       = pc_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Self-checking bench for lc3_fetch_unit: directed cases plus randomized
// fetch/deliver transactions against a transaction-level PC/MAR/IR model.
module tb_lc3_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        Clk;
  logic        Reset_n;
  logic        Run;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic        addr1_sel;
  logic [1:0]  addr2_sel;
  logic [15:0] base_reg;
  logic [15:0] pc;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model of architectural state.
  logic [15:0] m_pc;
  logic [15:0] m_mar;
  logic [15:0] m_ir;

  lc3_fetch_unit #(
    .RESET_PC(RESET_PC),
    .DATA_W  (16)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Run      (Run),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .ir       (ir),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .redirect (redirect),
    .addr1_sel(addr1_sel),
    .addr2_sel(addr2_sel),
    .base_reg (base_reg),
    .pc       (pc),
    .busy     (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Target from LC-3 rules using signed integer offsets.
  function automatic logic [15:0] ref_target(input logic [15:0] cur_pc, input logic [15:0] cur_ir,
                                             input logic [15:0] base, input logic a1,
                                             input logic [1:0] a2);
    int off;
    int b;
    int s;
    case (a2)
      2'd0: off = 0;
      2'd1: begin off = int'(cur_ir[5:0]);  if (off >= 32)   off -= 64;   end
      2'd2: begin off = int'(cur_ir[8:0]);  if (off >= 256)  off -= 512;  end
      default: begin off = int'(cur_ir[10:0]); if (off >= 1024) off -= 2048; end
    endcase
    b = a1 ? int'(base) : int'(cur_pc);
    s = b + off + 65536;
    return s[15:0];
  endfunction

  // DUT must be in REQ; stall `delay` cycles then accept `word`.
  task automatic fetch(input int delay, input logic [15:0] word);
    for (int i = 0; i < delay; i++) begin
      mem_ready = 1'b0;
      mem_rdata = 16'($urandom);
      tick();
      check("req_held", mem_req, 1'b1);
      check("mar_held", mem_addr, m_mar);
      check("pc_held", pc, m_pc);
    end
    mem_ready = 1'b1;
    mem_rdata = word;
    redirect  = 1'($urandom);
    tick();
    mem_ready = 1'b0;
    redirect  = 1'b0;
    m_ir = word;
    m_pc = m_pc + 16'd1;
    check("fetch_ir_valid", ir_valid, 1'b1);
    check("fetch_ir", ir, m_ir);
    check("fetch_pc", pc, m_pc);
    check("fetch_req_low", mem_req, 1'b0);
  endtask

  // DUT must be in HOLD; wait then have the decoder accept.
  task automatic deliver(input int wait_cyc, input logic rd, input logic a1, input logic [1:0] a2,
                         input logic [15:0] base, input logic run_next);
    logic [15:0] exp;
    for (int i = 0; i < wait_cyc; i++) begin
      ir_ready  = 1'b0;
      redirect  = 1'($urandom);
      mem_ready = 1'($urandom);
      base_reg  = 16'($urandom);
      tick();
      check("hold_ir", ir, m_ir);
      check("hold_valid", ir_valid, 1'b1);
      check("hold_pc", pc, m_pc);
    end
    exp       = rd ? ref_target(m_pc, m_ir, base, a1, a2) : m_pc;
    ir_ready  = 1'b1;
    redirect  = rd;
    addr1_sel = a1;
    addr2_sel = a2;
    base_reg  = base;
    Run       = run_next;
    mem_ready = 1'b0;
    tick();
    ir_ready = 1'b0;
    redirect = 1'b0;
    m_pc  = exp;
    m_mar = exp;
    check("dlv_valid_drop", ir_valid, 1'b0);
    check("dlv_mar", mem_addr, exp);
    check("dlv_pc", pc, exp);
    check("dlv_req", mem_req, run_next);
    check("dlv_busy", busy, run_next);
  endtask

  task automatic idle_restart(input int n);
    for (int i = 0; i < n; i++) begin
      Run       = 1'b0;
      mem_ready = 1'($urandom);
      tick();
      check("idle_req", mem_req, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_pc", pc, m_pc);
    end
    mem_ready = 1'b0;
    Run       = 1'b1;
    tick();
    m_mar = m_pc;
    check("restart_req", mem_req, 1'b1);
    check("restart_mar", mem_addr, m_mar);
  endtask

  initial begin
    logic run_next;
    Reset_n   = 1'b1;
    Run       = 1'b0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    ir_ready  = 1'b0;
    redirect  = 1'b0;
    addr1_sel = 1'b0;
    addr2_sel = 2'd0;
    base_reg  = '0;
    #2 Reset_n = 1'b0;
    #10;
    check("rst_pc", pc, RESET_PC);
    check("rst_mar", mem_addr, RESET_PC);
    check("rst_ir", ir, 16'h0000);
    check("rst_ir_valid", ir_valid, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge Clk) Reset_n = 1'b1;
    m_pc  = RESET_PC;
    m_mar = RESET_PC;
    m_ir  = 16'h0000;
    tick();
    check("idle_no_run", busy, 1'b0);

    // Test 1: immediate fetch from address 0.
    Run = 1'b1;
    tick();
    check("t1_req", mem_req, 1'b1);
    check("t1_addr", mem_addr, 16'h0000);
    fetch(0, 16'h1234);
    check("t1_ir", ir, 16'h1234);
    check("t1_pc", pc, 16'h0001);
    deliver(0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1);

    // Test 2: memory stall.
    fetch(3, 16'h5A5A);
    deliver(1, 1'b1, 1'b1, 2'd0, 16'h3000, 1'b1);

    // Test 3: BR with off9 = -2.
    fetch(0, 16'h0FFE);
    check("t3_pc", pc, 16'h3001);
    deliver(0, 1'b1, 1'b0, 2'd2, 16'h0000, 1'b1);
    check("t3_target", mem_addr, 16'h2FFF);

    // Test 4: JSR off11 and base+off6 wrap.
    fetch(0, 16'h0000);
    deliver(0, 1'b1, 1'b1, 2'd0, 16'h000F, 1'b1);
    fetch(1, 16'h4BFF);
    check("t4_pc", pc, 16'h0010);
    deliver(0, 1'b1, 1'b0, 2'd3, 16'h0000, 1'b1);
    check("t4_jsr", mem_addr, 16'h040F);
    fetch(0, 16'h0001);
    deliver(0, 1'b1, 1'b1, 2'd1, 16'hFFFF, 1'b1);
    check("t4_wrap", mem_addr, 16'h0000);

    // Randomized transactions.
    for (int t = 0; t < 150; t++) begin
      fetch($urandom_range(0, 3), 16'($urandom));
      run_next = ($urandom_range(0, 3) != 0);
      deliver($urandom_range(0, 2), 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom),
              run_next);
      if (!run_next) idle_restart($urandom_range(1, 3));
    end

    // Test 5: PC wrap, Run dropped during REQ.
    fetch(0, 16'h0000);
    deliver(0, 1'b1, 1'b1, 2'd0, 16'hFFFF, 1'b1);
    check("t5_mar", mem_addr, 16'hFFFF);
    Run = 1'b0;
    fetch(2, 16'hBEEF);
    check("t5_wrap", pc, 16'h0000);
    deliver(0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      tick();
      check("t5_idle_req", mem_req, 1'b0);
      check("t5_idle_busy", busy, 1'b0);
      check("t5_idle_ir", ir, 16'hBEEF);
    end
    mem_ready = 1'b0;

    // Test 6: asynchronous reset mid-REQ.
    Run = 1'b1;
    tick();
    check("t6_req", mem_req, 1'b1);
    #2;
    Reset_n   = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'hDEAD;
    #1;
    check("t6_req_drop", mem_req, 1'b0);
    check("t6_pc", pc, RESET_PC);
    check("t6_busy", busy, 1'b0);
    check("t6_ir", ir, 16'h0000);
    Run = 1'b0;
    @(negedge Clk) Reset_n = 1'b1;
    tick();
    check("t6_late_ready_req", mem_req, 1'b0);
    check("t6_late_ready_ir", ir, 16'h0000);
    check("t6_late_ready_valid", ir_valid, 1'b0);
    mem_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
